// File: rtl/quadrature_hall_emulator_module.sv
// -----------------------------------------------------------------------------
// quadrature_hall_emulator_module
//
// Emulates a HEDS-9040 quadrature encoder plus the three Hall sensors of a PMSM
// rotor that turns at a commanded step period and direction. Quadrature and
// Hall outputs are both derived from one shared mechanical step, so they stay
// phase-locked across wrap-around and direction reversal.
//
// Hall sectors are tracked with an exact rational accumulator: each step adds
// (or removes) K = 6*POLE_PAIRS to a counter modulo 4*LINES_PER_REV, and every
// overflow (underflow) advances (retreats) the Hall sector by one. This yields
// exactly 6*POLE_PAIRS sectors per revolution without drift.
//
// Optional feature macro: QUAD_INDEX_EN
//   When defined, adds heds_9040_ch_i_out, high only while the position is 0.
//
// Ports:
//   sys_clk              in   system clock, rising edge
//   reset                in   asynchronous active-high reset
//   enable_in            in   1 = run, 0 = freeze timer/position/outputs
//   cmd_valid_in         in   new period/direction command offered
//   cmd_ready_out        out  command can be accepted (no command pending)
//   cmd_period_in        in   sys_clk cycles per quadrature state, 0 = stop
//   cmd_direction_in     in   0 = forward, 1 = reverse
//   heds_9040_ch_a_out   out  quadrature channel A
//   heds_9040_ch_b_out   out  quadrature channel B
//   hall_u_out/v/w       out  Hall sensor signals
//   mech_position_out    out  quadrature state count 0 .. 4*LINES_PER_REV-1
//   step_out             out  one-cycle pulse in the cycle the outputs changed
//   heds_9040_ch_i_out   out  index channel (only with QUAD_INDEX_EN)
// -----------------------------------------------------------------------------
module quadrature_hall_emulator_module #(
    parameter int LINES_PER_REV = 2048,
    parameter int POLE_PAIRS    = 7,
    parameter int PERIOD_WIDTH  = 16
) (
    input  logic                                   sys_clk,
    input  logic                                   reset,
    input  logic                                   enable_in,
    input  logic                                   cmd_valid_in,
    output logic                                   cmd_ready_out,
    input  logic [PERIOD_WIDTH-1:0]                cmd_period_in,
    input  logic                                   cmd_direction_in,
    output logic                                   heds_9040_ch_a_out,
    output logic                                   heds_9040_ch_b_out,
    output logic                                   hall_u_out,
    output logic                                   hall_v_out,
    output logic                                   hall_w_out,
    output logic [$clog2(4*LINES_PER_REV)-1:0]     mech_position_out,
    output logic                                   step_out
`ifdef QUAD_INDEX_EN
    ,
    output logic                                   heds_9040_ch_i_out
`endif
);

    localparam int                   STATES     = 4 * LINES_PER_REV;
    localparam int                   POS_W      = $clog2(STATES);
    localparam logic [POS_W-1:0]     POS_MAX    = POS_W'(STATES - 1);
    localparam logic [POS_W-1:0]     POS_ONE    = POS_W'(1);
    localparam logic [POS_W-1:0]     HALL_K     = POS_W'(6 * POLE_PAIRS);
    localparam logic [POS_W:0]       STATES_EXT = (POS_W + 1)'(STATES);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);

    // Quadrature phase to {a,b}; forward order is 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] quad_encode(input logic [1:0] phase);
        logic [1:0] ab;
        case (phase)
            2'd0:    ab = 2'b10;
            2'd1:    ab = 2'b11;
            2'd2:    ab = 2'b01;
            2'd3:    ab = 2'b00;
            default: ab = 2'b10;
        endcase
        return ab;
    endfunction

    // Hall sector to {u,v,w}.
    function automatic logic [2:0] hall_encode(input logic [2:0] sector);
        logic [2:0] uvw;
        case (sector)
            3'd0:    uvw = 3'b101;
            3'd1:    uvw = 3'b100;
            3'd2:    uvw = 3'b110;
            3'd3:    uvw = 3'b010;
            3'd4:    uvw = 3'b011;
            3'd5:    uvw = 3'b001;
            default: uvw = 3'b101;
        endcase
        return uvw;
    endfunction

    // Sector + 1 modulo 6; out-of-range codes recover to sector 0.
    function automatic logic [2:0] sector_inc(input logic [2:0] sector);
        logic [2:0] nxt;
        case (sector)
            3'd0:    nxt = 3'd1;
            3'd1:    nxt = 3'd2;
            3'd2:    nxt = 3'd3;
            3'd3:    nxt = 3'd4;
            3'd4:    nxt = 3'd5;
            3'd5:    nxt = 3'd0;
            default: nxt = 3'd0;
        endcase
        return nxt;
    endfunction

    // Sector - 1 modulo 6; out-of-range codes recover to sector 0.
    function automatic logic [2:0] sector_dec(input logic [2:0] sector);
        logic [2:0] nxt;
        case (sector)
            3'd0:    nxt = 3'd5;
            3'd1:    nxt = 3'd0;
            3'd2:    nxt = 3'd1;
            3'd3:    nxt = 3'd2;
            3'd4:    nxt = 3'd3;
            3'd5:    nxt = 3'd4;
            default: nxt = 3'd0;
        endcase
        return nxt;
    endfunction

    // Command / timing state
    logic [PERIOD_WIDTH-1:0] act_period_q,  act_period_d;
    logic                    act_dir_q,     act_dir_d;
    logic [PERIOD_WIDTH-1:0] pend_period_q, pend_period_d;
    logic                    pend_dir_q,    pend_dir_d;
    logic                    pend_q,        pend_d;
    logic [PERIOD_WIDTH-1:0] timer_q,       timer_d;

    // Rotor state
    logic [POS_W-1:0]        pos_q,    pos_d;
    logic [1:0]              quad_q,   quad_d;
    logic [POS_W-1:0]        acc_q,    acc_d;
    logic [2:0]              sector_q, sector_d;
    logic [POS_W:0]          acc_sum_s;

    // Registered outputs
    logic [1:0]              ab_q;
    logic [2:0]              hall_q;
    logic                    step_q;
    logic                    ready_q;

    logic                    accept_s;
    logic                    running_s;
    logic                    step_fire_s;
    logic                    apply_s;

    // Step timer, command acceptance and command apply decisions
    always_comb begin
        accept_s      = cmd_valid_in && !pend_q;
        running_s     = enable_in && (act_period_q != '0);
        step_fire_s   = 1'b0;
        apply_s       = 1'b0;
        timer_d       = timer_q;
        act_period_d  = act_period_q;
        act_dir_d     = act_dir_q;
        pend_d        = pend_q;
        pend_period_d = pend_period_q;
        pend_dir_d    = pend_dir_q;

        if (running_s) begin
            if (timer_q == PERIOD_ONE) begin
                step_fire_s = 1'b1;
                timer_d     = act_period_q;
            end else if (timer_q == '0) begin
                // Unreachable while running; recover by restarting the interval.
                timer_d = act_period_q;
            end else begin
                timer_d = timer_q - PERIOD_ONE;
            end
        end else begin
            timer_d = timer_q;
        end

        // A pending command waits for the step boundary unless nothing is
        // stepping (stopped or frozen), in which case it applies at once.
        apply_s = pend_q && (step_fire_s || (act_period_q == '0) || !enable_in);

        if (apply_s) begin
            act_period_d = pend_period_q;
            act_dir_d    = pend_dir_q;
            timer_d      = pend_period_q;
            pend_d       = 1'b0;
        end else begin
            act_period_d = act_period_q;
            act_dir_d    = act_dir_q;
        end

        // accept and apply are exclusive: accept needs pend_q low, apply high.
        if (accept_s) begin
            pend_d        = 1'b1;
            pend_period_d = cmd_period_in;
            pend_dir_d    = cmd_direction_in;
        end else begin
            pend_period_d = pend_period_q;
            pend_dir_d    = pend_dir_q;
        end
    end

    // Advance position, quadrature phase and Hall accumulator on a step
    always_comb begin
        pos_d     = pos_q;
        quad_d    = quad_q;
        acc_d     = acc_q;
        sector_d  = sector_q;
        acc_sum_s = '0;

        if (step_fire_s) begin
            // The step that closes an interval always uses the old direction;
            // a new direction only governs steps after the apply edge.
            if (!act_dir_q) begin
                pos_d     = (pos_q == POS_MAX) ? '0 : (pos_q + POS_ONE);
                quad_d    = quad_q + 2'd1;
                acc_sum_s = {1'b0, acc_q} + {1'b0, HALL_K};
                if (acc_sum_s >= STATES_EXT) begin
                    acc_sum_s = acc_sum_s - STATES_EXT;
                    sector_d  = sector_inc(sector_q);
                end else begin
                    sector_d  = sector_q;
                end
                acc_d = acc_sum_s[POS_W-1:0];
            end else begin
                pos_d  = (pos_q == '0) ? POS_MAX : (pos_q - POS_ONE);
                quad_d = quad_q - 2'd1;
                if (acc_q < HALL_K) begin
                    acc_sum_s = {1'b0, acc_q} + STATES_EXT - {1'b0, HALL_K};
                    sector_d  = sector_dec(sector_q);
                end else begin
                    acc_sum_s = {1'b0, acc_q} - {1'b0, HALL_K};
                    sector_d  = sector_q;
                end
                acc_d = acc_sum_s[POS_W-1:0];
            end
        end else begin
            pos_d = pos_q;
        end
    end

    // Command and timer registers
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            act_period_q  <= '0;
            act_dir_q     <= 1'b0;
            pend_period_q <= '0;
            pend_dir_q    <= 1'b0;
            pend_q        <= 1'b0;
            timer_q       <= '0;
        end else begin
            act_period_q  <= act_period_d;
            act_dir_q     <= act_dir_d;
            pend_period_q <= pend_period_d;
            pend_dir_q    <= pend_dir_d;
            pend_q        <= pend_d;
            timer_q       <= timer_d;
        end
    end

    // Rotor state registers
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            pos_q    <= '0;
            quad_q   <= 2'd0;
            acc_q    <= '0;
            sector_q <= 3'd0;
        end else begin
            pos_q    <= pos_d;
            quad_q   <= quad_d;
            acc_q    <= acc_d;
            sector_q <= sector_d;
        end
    end

    // Output registers, decoded from next state so they change with it
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            ab_q    <= 2'b10;
            hall_q  <= 3'b101;
            step_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            ab_q    <= quad_encode(quad_d);
            hall_q  <= hall_encode(sector_d);
            step_q  <= step_fire_s;
            ready_q <= !pend_d;
        end
    end

    assign heds_9040_ch_a_out = ab_q[1];
    assign heds_9040_ch_b_out = ab_q[0];
    assign hall_u_out         = hall_q[2];
    assign hall_v_out         = hall_q[1];
    assign hall_w_out         = hall_q[0];
    assign mech_position_out  = pos_q;
    assign step_out           = step_q;
    assign cmd_ready_out      = ready_q;

`ifdef QUAD_INDEX_EN
    logic index_q;

    // Index pulse register: high exactly while the position is 0
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            index_q <= 1'b1;
        end else begin
            index_q <= (pos_d == '0);
        end
    end

    assign heds_9040_ch_i_out = index_q;
`else
    // Index channel not built.
`endif

endmodule

// File: tb/tb_quadrature_hall_emulator_module.sv
module tb_quadrature_hall_emulator_module;

    localparam int LPR    = 2048;
    localparam int PP     = 7;
    localparam int PW     = 16;
    localparam int STATES = 4 * LPR;
    localparam int K      = 6 * PP;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable_in = 1'b0;
    logic          cmd_valid_in = 1'b0;
    logic          cmd_ready_out;
    logic [PW-1:0] cmd_period_in = '0;
    logic          cmd_direction_in = 1'b0;
    logic          heds_9040_ch_a_out, heds_9040_ch_b_out;
    logic          hall_u_out, hall_v_out, hall_w_out;
    logic [12:0]   mech_position_out;
    logic          step_out;
`ifdef QUAD_INDEX_EN
    logic          heds_9040_ch_i_out;
`endif

    quadrature_hall_emulator_module #(
        .LINES_PER_REV(LPR), .POLE_PAIRS(PP), .PERIOD_WIDTH(PW)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .enable_in(enable_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_period_in(cmd_period_in), .cmd_direction_in(cmd_direction_in),
        .heds_9040_ch_a_out(heds_9040_ch_a_out), .heds_9040_ch_b_out(heds_9040_ch_b_out),
        .hall_u_out(hall_u_out), .hall_v_out(hall_v_out), .hall_w_out(hall_w_out),
        .mech_position_out(mech_position_out), .step_out(step_out)
`ifdef QUAD_INDEX_EN
        , .heds_9040_ch_i_out(heds_9040_ch_i_out)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int       edge_n;
        bit       step;
        bit       rdy;
        bit [1:0] ab;
        bit [2:0] hall;
        int       pos;
        bit       idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    int   steps_seen = 0;
    int   hall_edges = 0;
    int   first_hall_step = 0;
    bit [2:0] prev_hall = 3'b101;

    // Reference model: unwrapped signed step count plus command bookkeeping.
    longint m_n = 0;
    int     m_act_p = 0;
    bit     m_act_dir = 1'b0;
    bit     m_pend = 1'b0;
    int     m_pend_p = 0;
    bit     m_pend_dir = 1'b0;
    int     m_elapsed = 0;
    int     m_steps = 0;
    bit     m_last_step = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    function automatic longint fmod(input longint x, input longint m);
        return ((x % m) + m) % m;
    endfunction

    function automatic bit [2:0] hall_of(input int s);
        case (s)
            0: return 3'b101;
            1: return 3'b100;
            2: return 3'b110;
            3: return 3'b010;
            4: return 3'b011;
            default: return 3'b001;
        endcase
    endfunction

    function automatic bit [1:0] ab_of(input int q);
        case (q)
            0: return 2'b10;
            1: return 2'b11;
            2: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic exp_t predict(input int edge_n, input bit step);
        exp_t   r;
        longint scaled;
        longint sec;
        r.edge_n = edge_n;
        r.step   = step;
        r.rdy    = !m_pend;
        r.pos    = int'(fmod(m_n, STATES));
        r.ab     = ab_of(int'(fmod(m_n, 4)));
        scaled   = m_n * K;
        sec      = (scaled - fmod(scaled, STATES)) / STATES;
        r.hall   = hall_of(int'(fmod(sec, 6)));
        r.idx    = (r.pos == 0);
        return r;
    endfunction

    // Drive inputs for the next edge, predict its outcome, wait for the edge.
    task automatic tick(input bit en, input bit v, input int per, input bit dir);
        bit step;
        bit acc;
        enable_in        = en;
        cmd_valid_in     = v;
        cmd_period_in    = PW'(per);
        cmd_direction_in = dir;
        step = 1'b0;
        if (en && m_act_p != 0) begin
            m_elapsed++;
            if (m_elapsed >= m_act_p) begin
                step      = 1'b1;
                m_elapsed = 0;
                m_n       = m_act_dir ? m_n - 1 : m_n + 1;
                m_steps++;
            end
        end
        acc = v && !m_pend;
        if (m_pend && (step || m_act_p == 0 || !en)) begin
            m_act_p   = m_pend_p;
            m_act_dir = m_pend_dir;
            m_elapsed = 0;
            m_pend    = 1'b0;
        end
        if (acc) begin
            m_pend     = 1'b1;
            m_pend_p   = per;
            m_pend_dir = dir;
        end
        m_last_step = step;
        exp_q.push_back(predict(cyc + 1, step));
        mon_en = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_a"}, heds_9040_ch_a_out, 1);
        chk({tag, "_b"}, heds_9040_ch_b_out, 0);
        chk({tag, "_hall"}, {hall_u_out, hall_v_out, hall_w_out}, 3'b101);
        chk({tag, "_pos"}, mech_position_out, 0);
        chk({tag, "_ready"}, cmd_ready_out, 1);
        chk({tag, "_step"}, step_out, 0);
`ifdef QUAD_INDEX_EN
        chk({tag, "_index"}, heds_9040_ch_i_out, 1);
`endif
    endtask

    // Asynchronous reset between edges, then release on a falling edge.
    task automatic do_reset(input string tag);
        #2;
        reset  = 1'b1;
        mon_en = 1'b0;
        #1;
        check_reset_values(tag);
        exp_q.delete();
        m_n = 0; m_act_p = 0; m_act_dir = 1'b0; m_pend = 1'b0;
        m_pend_p = 0; m_pend_dir = 1'b0; m_elapsed = 0;
        enable_in = 1'b0; cmd_valid_in = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_model_step();
        int guard;
        guard = 0;
        m_last_step = 1'b0;
        while (!m_last_step && guard < 64) begin
            tick(1'b1, 1'b0, 0, 1'b0);
            guard++;
        end
        chk("step_wait_bound", m_last_step, 1);
    endtask

    // Scoreboard monitor: pops one expectation per cycle and compares.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 0, 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("cycle_sync", cyc, mon_e.edge_n);
                chk("step_out", step_out, mon_e.step);
                chk("cmd_ready", cmd_ready_out, mon_e.rdy);
                chk("quad_ab", {heds_9040_ch_a_out, heds_9040_ch_b_out}, mon_e.ab);
                chk("hall_uvw", {hall_u_out, hall_v_out, hall_w_out}, mon_e.hall);
                chk("position", mech_position_out, mon_e.pos);
`ifdef QUAD_INDEX_EN
                chk("index", heds_9040_ch_i_out, mon_e.idx);
`endif
                if (step_out) begin
                    steps_seen++;
                    if ({hall_u_out, hall_v_out, hall_w_out} != prev_hall) begin
                        hall_edges++;
                        if (first_hall_step == 0) first_hall_step = steps_seen;
                    end
                end
                prev_hall = {hall_u_out, hall_v_out, hall_w_out};
            end
        end
    end

    initial begin
        int guard;
        int frz;
        @(negedge sys_clk);
        do_reset("reset0");

        // Reverse at period 2 from reset, then reset while running.
        tick(1'b1, 1'b1, 2, 1'b1);
        wait_model_step();
        repeat (5) tick(1'b1, 1'b0, 0, 1'b0);
        do_reset("reset_mid");

        // One full forward revolution at period 4.
        steps_seen = 0; hall_edges = 0; first_hall_step = 0;
        prev_hall = {hall_u_out, hall_v_out, hall_w_out};
        m_steps = 0;
        tick(1'b1, 1'b1, 4, 1'b0);
        guard = 0;
        while (m_steps < STATES && guard < 40000) begin
            tick(1'b1, 1'b0, 0, 1'b0);
            guard++;
        end
        #1;
        chk("rev_guard", (m_steps == STATES), 1);
        chk("rev_steps", steps_seen, STATES);
        chk("rev_pos", mech_position_out, 0);
        chk("rev_hall", {hall_u_out, hall_v_out, hall_w_out}, 3'b101);
        chk("rev_hall_edges", hall_edges, 42);
        chk("rev_first_hall_step", first_hall_step, 196);

        // Switch to period 10, then reverse at period 3 mid-interval.
        tick(1'b1, 1'b1, 10, 1'b0);
        repeat (40) tick(1'b1, 1'b0, 0, 1'b0);
        wait_model_step();
        repeat (3) tick(1'b1, 1'b0, 0, 1'b0);
        tick(1'b1, 1'b1, 3, 1'b1);
        #1;
        chk("ready_drop", cmd_ready_out, 0);
        repeat (40) tick(1'b1, 1'b0, 0, 1'b0);
        #1;
        chk("ready_back", cmd_ready_out, 1);

        // Freeze 50 cycles in the middle of a period-9 interval.
        tick(1'b1, 1'b1, 9, 1'b0);
        repeat (20) tick(1'b1, 1'b0, 0, 1'b0);
        wait_model_step();
        repeat (4) tick(1'b1, 1'b0, 0, 1'b0);
        repeat (50) tick(1'b0, 1'b0, 0, 1'b0);
        repeat (30) tick(1'b1, 1'b0, 0, 1'b0);

        // Randomized commands, directions and freezes.
        frz = 0;
        for (int i = 0; i < 3000; i++) begin
            if (frz > 0) frz--;
            else if ($urandom_range(0, 99) == 0) frz = $urandom_range(1, 20);
            tick(frz == 0, ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 9),
                 1'($urandom_range(0, 1)));
        end

        #1;
        mon_en = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
